// File: rtl/capture_uart_dump_pkg.sv
// Shared FSM state type and frame constants for the capture RAM UART dumper.
package capture_uart_dump_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int         CNT_W    = 16;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    CNT_HI,
    CNT_LO,
    RD_REQ,
    RD_WAIT,
    SEND,
    TAIL,
    DONE
  } state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART byte serializer; ready rises in the final stop-bit cycle so the
// next byte can start with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  logic          active;
  logic [3:0]    bit_idx;
  logic [TW-1:0] tmr;
  logic [9:0]    shreg;
  logic          bit_end;
  logic          last;

  assign bit_end = (tmr == '0);
  assign last    = active && bit_end && (bit_idx == 4'd9);
  assign ready   = !active || last;
  assign tx      = active ? shreg[0] : 1'b1;

  // shreg holds {stop, data, start}; bit 0 is always the bit on the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      bit_idx <= 4'd0;
      tmr     <= '0;
      shreg   <= '1;
    end else if (valid && ready) begin
      active  <= 1'b1;
      bit_idx <= 4'd0;
      tmr     <= TW'(CLKS_PER_BIT - 1);
      shreg   <= {1'b1, data, 1'b0};
    end else if (active) begin
      if (bit_end) begin
        if (last) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
          tmr     <= TW'(CLKS_PER_BIT - 1);
        end
      end else begin
        tmr <= tmr - TW'(1);
      end
    end
  end

endmodule

// File: rtl/capture_uart_dump.sv
// Streams a header, sample count and the captured samples out over UART.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte to each frame.
module capture_uart_dump
  import capture_uart_dump_pkg::*;
#(
  parameter int BUS_WIDTH    = 8,
  parameter int MEMORY_SIZE  = 1024,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(MEMORY_SIZE):0]   sample_cnt,
  output logic [$clog2(MEMORY_SIZE)-1:0] rd_addr,
  input  logic [BUS_WIDTH-1:0]           rd_data,
  output logic                           tx,
  output logic                           busy,
  output logic                           done
);

  // state   | meaning
  // IDLE    | waiting for start
  // HDR     | offering header byte 0xA5
  // CNT_HI  | offering count[15:8]
  // CNT_LO  | offering count[7:0]
  // RD_REQ  | rd_addr presents the current sample index
  // RD_WAIT | RAM data returns, captured into the sample buffer
  // SEND    | offering sample bytes, LSB first
  // TAIL    | checksum byte when enabled, otherwise pass-through
  // DONE    | waiting for the last stop bit to finish

  localparam int AW = $clog2(MEMORY_SIZE);
  localparam int CW = AW + 1;
  localparam int NB = BUS_WIDTH / 8;
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        index_q;
  logic [CW-1:0]        index_next;
  logic [CW-1:0]        count_sat;
  logic [CNT_W-1:0]     count_f;
  logic [AW-1:0]        addr_q;
  logic [BUS_WIDTH-1:0] buf_q;
  logic [SW-1:0]        sel_q;
  logic                 last_byte;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  assign count_sat  = (sample_cnt > CW'(MEMORY_SIZE)) ? CW'(MEMORY_SIZE) : sample_cnt;
  assign count_f    = CNT_W'(count_q);
  assign index_next = index_q + CW'(1);
  assign last_byte  = (sel_q == SW'(NB - 1));
  assign busy       = (state_q != IDLE);
  assign rd_addr    = addr_q;

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = HDR_BYTE;
    done     = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        tx_valid = 1'b1;
        if (tx_ready) state_d = CNT_HI;
      end
      CNT_HI: begin
        tx_valid = 1'b1;
        tx_data  = count_f[15:8];
        if (tx_ready) state_d = CNT_LO;
      end
      CNT_LO: begin
        tx_valid = 1'b1;
        tx_data  = count_f[7:0];
        if (tx_ready) state_d = (count_q == '0) ? TAIL : RD_REQ;
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = buf_q[7:0];
        if (tx_ready && last_byte) state_d = (index_next < count_q) ? RD_REQ : TAIL;
      end
`ifdef DUMP_CHECKSUM_EN
      TAIL: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = DONE;
      end
`else
      TAIL: state_d = DONE;
`endif
      // the last byte is still on the line; finish when its stop bit ends
      DONE: begin
        if (tx_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q <= count_sat;
            index_q <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
          end
        end
        RD_WAIT: buf_q <= rd_data;
        SEND: begin
          if (tx_ready) begin
            if (last_byte) begin
              sel_q   <= '0;
              index_q <= index_next;
              // address only moves to a sample that will be read, so it stays in range
              if (index_next < count_q) addr_q <= AW'(index_next);
            end else begin
              sel_q <= sel_q + SW'(1);
              buf_q <= buf_q >> 8;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'h00;
    end else if (state_q == IDLE && start) begin
      csum_q <= 8'h00;
    end else if (tx_valid && tx_ready &&
                 (state_q == CNT_HI || state_q == CNT_LO || state_q == SEND)) begin
      csum_q <= csum_q ^ tx_data;
    end
  end
`endif

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_capture_uart_dump.sv
// Bench for capture_uart_dump: decodes the UART line and compares frames with a
// byte-list model built from the frame rules (honours DUMP_CHECKSUM_EN).
`timescale 1ns/1ps
module tb_capture_uart_dump;

  localparam int CPB    = 4;
  localparam int MEM8   = 1024;
  localparam int MEM16  = 16;
  localparam int BYTE_T = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [10:0] sample_cnt8;
  logic [9:0]  rd_addr8;
  logic [7:0]  rd_data8;
  logic        tx8, busy8, done8;
  logic [4:0]  sample_cnt16;
  logic [3:0]  rd_addr16;
  logic [15:0] rd_data16;
  logic        tx16, busy16, done16;

  logic [7:0]  ram8  [MEM8];
  logic [15:0] ram16 [MEM16];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int timing_err = 0;

  logic use16 = 1'b0;
  logic mon_tx;
  assign mon_tx = use16 ? tx16 : tx8;

  logic [7:0] rx_q[$];
  int         st_q[$];
  logic [7:0] exp_q[$];
  logic       smp[40];

  capture_uart_dump #(.BUS_WIDTH(8), .MEMORY_SIZE(MEM8), .CLKS_PER_BIT(CPB)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sample_cnt(sample_cnt8),
    .rd_addr(rd_addr8), .rd_data(rd_data8), .tx(tx8), .busy(busy8), .done(done8));

  capture_uart_dump #(.BUS_WIDTH(16), .MEMORY_SIZE(MEM16), .CLKS_PER_BIT(CPB)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sample_cnt(sample_cnt16),
    .rd_addr(rd_addr16), .rd_data(rd_data16), .tx(tx16), .busy(busy16), .done(done16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rd_data8  <= ram8[rd_addr8];
    rd_data16 <= ram16[rd_addr16];
  end

  // line decoder: 40 samples per byte, each checked against the ideal waveform
  initial begin : monitor
    int st;
    bit ab, bad;
    logic [7:0] b;
    logic e;
    forever begin
      @(negedge clk);
      if (mon_tx === 1'b0 && !rst) begin
        st = cyc;
        ab = 0;
        for (int j = 0; j < 40; j++) begin
          if (j > 0) @(negedge clk);
          smp[j] = mon_tx;
          if (rst) ab = 1;
        end
        if (!ab) begin
          for (int i = 0; i < 8; i++) b[i] = smp[4*(i+1)+2];
          bad = 0;
          for (int j = 0; j < 40; j++) begin
            e = (j < 4) ? 1'b0 : (j >= 36) ? 1'b1 : b[j/4-1];
            if (smp[j] !== e) bad = 1;
          end
          if (bad) timing_err++;
          rx_q.push_back(b);
          st_q.push_back(st);
        end
      end
    end
  end

  task automatic build_expected(input bit wide, input int sc);
    int cnt, nb;
    logic [15:0] w;
    logic [7:0] x;
    exp_q.delete();
    cnt = (sc > (wide ? MEM16 : MEM8)) ? (wide ? MEM16 : MEM8) : sc;
    nb  = wide ? 2 : 1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'((cnt >> 8) & 255));
    exp_q.push_back(8'(cnt & 255));
    for (int i = 0; i < cnt; i++) begin
      w = wide ? ram16[i] : {8'h00, ram8[i]};
      for (int k = 0; k < nb; k++) exp_q.push_back(8'(w >> (8*k)));
    end
`ifdef DUMP_CHECKSUM_EN
    x = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  function automatic int first_diff();
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int bad_gaps();
    int n = 0;
    for (int i = 1; i < st_q.size(); i++) if (st_q[i] - st_q[i-1] != BYTE_T) n++;
    return n;
  endfunction

  task automatic run_frame(input bit wide, input int sc, input int restart_at,
                           output int dones, output int max_addr, output bit moved,
                           output bit busy_seen, output bit timed_out, output int accept);
    int bound, extra;
    use16 = wide;
    rx_q.delete();
    st_q.delete();
    dones = 0; max_addr = 0; moved = 0; busy_seen = 0; timed_out = 1; extra = 0;
    bound = (((sc > MEM8) ? MEM8 : sc) + 4) * 2 * BYTE_T + 100;
    @(negedge clk);
    if (wide) begin sample_cnt16 = 5'(sc); start16 = 1'b1; end
    else      begin sample_cnt8  = 11'(sc); start8 = 1'b1; end
    accept = cyc + 1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      start8  = 1'b0;
      start16 = 1'b0;
      if (n == restart_at) begin start8 = 1'b1; sample_cnt8 = 11'd7; end
      if (n == 0) busy_seen = wide ? busy16 : busy8;
      if (!wide) begin
        if (rd_addr8 > max_addr) max_addr = rd_addr8;
        if (rd_addr8 != 0) moved = 1;
      end
      if ((wide ? done16 : done8) === 1'b1) dones++;
      if (dones > 0) begin
        extra++;
        if (extra == 15) begin timed_out = 0; break; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0; sample_cnt8 = '0; sample_cnt16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx8 !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
    checks++; if (rd_addr8 !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rd_addr8); end
    checks++; if (tx16 !== 1'b1 || busy16 !== 1'b0) begin failures++; $display("FAIL reset_wide got=%b%b exp=10", tx16, busy16); end
  endtask

  task automatic test_count3();
    int dn, mx, acc, d, te0, lat; bit mv, bs, to;
    build_expected(0, 3);
    te0 = timing_err;
    run_frame(0, 3, -1, dn, mx, mv, bs, to, acc);
    lat = (st_q.size() > 0) ? st_q[0] - acc : 999;
    d = first_diff();
    checks++; if (to) begin failures++; $display("FAIL cnt3_timeout got=no_done exp=done"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL cnt3_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    checks++; if (d >= 0) begin failures++; $display("FAIL cnt3_byte idx=%0d got=%h exp=%h", d, rx_q[d], exp_q[d]); end
    checks++; if (dn != 1) begin failures++; $display("FAIL cnt3_done got=%0d exp=1", dn); end
    checks++; if (!bs) begin failures++; $display("FAIL cnt3_busy got=0 exp=1"); end
    checks++; if (lat > 2 || lat < 0) begin failures++; $display("FAIL cnt3_latency got=%0d exp<=2", lat); end
    checks++; if (timing_err != te0) begin failures++; $display("FAIL cnt3_bit_timing got=%0d exp=0", timing_err - te0); end
    checks++; if (bad_gaps() != 0) begin failures++; $display("FAIL cnt3_gaps got=%0d exp=0", bad_gaps()); end
    checks++; if (busy8 !== 1'b0 || tx8 !== 1'b1) begin failures++; $display("FAIL cnt3_idle got=%b%b exp=01", busy8, tx8); end
  endtask

  task automatic test_count0();
    int dn, mx, acc, d; bit mv, bs, to;
    build_expected(0, 0);
    run_frame(0, 0, -1, dn, mx, mv, bs, to, acc);
    d = first_diff();
    checks++; if (to) begin failures++; $display("FAIL cnt0_timeout got=no_done exp=done"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL cnt0_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    checks++; if (d >= 0) begin failures++; $display("FAIL cnt0_byte idx=%0d got=%h exp=%h", d, rx_q[d], exp_q[d]); end
    checks++; if (mv) begin failures++; $display("FAIL cnt0_addr_moved got=1 exp=0"); end
    checks++; if (dn != 1) begin failures++; $display("FAIL cnt0_done got=%0d exp=1", dn); end
  endtask

  task automatic test_saturate();
    int dn, mx, acc, d; bit mv, bs, to;
    build_expected(0, 2000);
    run_frame(0, 2000, -1, dn, mx, mv, bs, to, acc);
    d = first_diff();
    checks++; if (to) begin failures++; $display("FAIL sat_timeout got=no_done exp=done"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL sat_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    checks++; if (d >= 0) begin failures++; $display("FAIL sat_byte idx=%0d got=%h exp=%h", d, rx_q[d], exp_q[d]); end
    checks++; if (rx_q.size() < 3 || rx_q[1] !== 8'h04 || rx_q[2] !== 8'h00) begin failures++; $display("FAIL sat_count_field got_size=%0d exp=0400", rx_q.size()); end
    checks++; if (mx != MEM8 - 1) begin failures++; $display("FAIL sat_max_addr got=%0d exp=%0d", mx, MEM8 - 1); end
    checks++; if (bad_gaps() != 0) begin failures++; $display("FAIL sat_gaps got=%0d exp=0", bad_gaps()); end
  endtask

  task automatic test_restart_ignored();
    int dn, mx, acc, d; bit mv, bs, to;
    build_expected(0, 4);
    run_frame(0, 4, 85, dn, mx, mv, bs, to, acc);
    d = first_diff();
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL restart_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    checks++; if (d >= 0) begin failures++; $display("FAIL restart_byte idx=%0d got=%h exp=%h", d, rx_q[d], exp_q[d]); end
    checks++; if (dn != 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", dn); end
    repeat (50) @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL restart_relaunch got_busy=%b exp=0", busy8); end
  endtask

  task automatic test_reset_mid_frame();
    int dn, mx, acc, d, dn_abort; bit mv, bs, to;
    use16 = 1'b0;
    dn_abort = 0;
    @(negedge clk);
    sample_cnt8 = 11'd5;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (170) begin
      @(negedge clk);
      if (done8 === 1'b1) dn_abort++;
    end
    rst = 1'b1;
    #1;
    checks++; if (tx8 !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done8 === 1'b1) dn_abort++;
    end
    checks++; if (dn_abort != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dn_abort); end
    build_expected(0, 1);
    run_frame(0, 1, -1, dn, mx, mv, bs, to, acc);
    d = first_diff();
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    checks++; if (d >= 0) begin failures++; $display("FAIL midrst_byte idx=%0d got=%h exp=%h", d, rx_q[d], exp_q[d]); end
    checks++; if (dn != 1) begin failures++; $display("FAIL midrst_done got=%0d exp=1", dn); end
  endtask

  task automatic test_random_frames();
    int dn, mx, acc, d, sc, te0; bit mv, bs, to;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) ram8[i] = 8'($urandom);
      sc = $urandom_range(1, 16);
      build_expected(0, sc);
      te0 = timing_err;
      run_frame(0, sc, -1, dn, mx, mv, bs, to, acc);
      d = first_diff();
      checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, rx_q.size(), exp_q.size()); end
      checks++; if (d >= 0) begin failures++; $display("FAIL rand%0d_byte idx=%0d got=%h exp=%h", it, d, rx_q[d], exp_q[d]); end
      checks++; if (dn != 1 || timing_err != te0) begin failures++; $display("FAIL rand%0d_done_timing got=%0d/%0d exp=1/0", it, dn, timing_err - te0); end
      checks++; if (mx != sc - 1) begin failures++; $display("FAIL rand%0d_max_addr got=%0d exp=%0d", it, mx, sc - 1); end
    end
    for (int i = 0; i < 16; i++) ram8[i] = 8'(i) ^ 8'h3C;
  endtask

  task automatic test_wide_bus();
    int dn, mx, acc, d, te0; bit mv, bs, to;
    for (int sc = 1; sc <= 3; sc += 2) begin
      build_expected(1, sc);
      te0 = timing_err;
      run_frame(1, sc, -1, dn, mx, mv, bs, to, acc);
      d = first_diff();
      checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL wide%0d_len got=%0d exp=%0d", sc, rx_q.size(), exp_q.size()); end
      checks++; if (d >= 0) begin failures++; $display("FAIL wide%0d_byte idx=%0d got=%h exp=%h", sc, d, rx_q[d], exp_q[d]); end
      checks++; if (timing_err != te0 || bad_gaps() != 0) begin failures++; $display("FAIL wide%0d_bit_timing got=%0d/%0d exp=0/0", sc, timing_err - te0, bad_gaps()); end
      checks++; if (dn != 1) begin failures++; $display("FAIL wide%0d_done got=%0d exp=1", sc, dn); end
    end
    use16 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM8; i++) ram8[i] = 8'(i) ^ 8'h3C;
    ram16[0] = 16'h1234;
    for (int i = 1; i < MEM16; i++) ram16[i] = 16'(i * 257) ^ 16'h3C3C;
    test_reset();
    test_count3();
    test_count0();
    test_restart_ignored();
    test_reset_mid_frame();
    test_random_frames();
    test_wide_bus();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
